// File: rtl/mac_int8_feeder.sv
// Initiator for the MAC_INT8 control/data interface: loads 3-row weight sets into the
// idle ping-pong bank, streams activations against the active bank, and qualifies results.
module mac_int8_feeder #(
  parameter int LEN_W   = 8,
  parameter int RES_LAT = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load_w,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [87:0]      w_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [95:0]      a_data,
  output logic [95:0]      mac_data_in,
  output logic             mac_load_bb_a,
  output logic             mac_load_bb_b,
  output logic             mac_load_buf_sel,
  output logic [1:0]       mac_feed_sel,
  output logic             mac_zero_en,
  output logic             res_valid,
  output logic             res_last,
  output logic             done,
  output logic             active_bank
);
  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, acnt_q, acnt_d;
  logic [1:0]         wcnt_q, wcnt_d;
  logic               bank_q, bank_d;
  logic               lbb_a_q, lbb_b_q;
  logic [95:0]        d1_q, d2_q;
  logic               sel1_q, sel_q;
  logic [RES_LAT:1]   vld_q, last_q;
  logic               cmd_hs, w_hs, a_hs, a_last, pipe_empty;

  assign cmd_ready  = (state_q == IDLE) && clr;
  assign w_ready    = (state_q == LOAD_W);
  assign a_ready    = (state_q == STREAM);
  assign cmd_hs     = cmd_valid && cmd_ready;
  assign w_hs       = w_valid && w_ready;
  assign a_hs       = a_valid && a_ready;
  assign a_last     = (acnt_q + LEN_W'(1)) == len_q;
  assign pipe_empty = ~|vld_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    acnt_d  = acnt_q;
    bank_d  = bank_q;
    unique case (state_q)
      IDLE: if (cmd_hs) begin
        wcnt_d = '0;
        acnt_d = '0;
        if (cmd_load_w)         state_d = LOAD_W;
        else if (cmd_len != '0) state_d = STREAM;
        else                    state_d = DRAIN;
      end
      LOAD_W: if (w_hs) begin
        if (wcnt_q == 2'd2) begin
          // Flip on the last row so the very next activation computes on the new set.
          wcnt_d  = '0;
          bank_d  = ~bank_q;
          state_d = (len_q != '0) ? STREAM : DRAIN;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      STREAM: if (a_hs) begin
        acnt_d = acnt_q + LEN_W'(1);
        if (a_last) state_d = DRAIN;
      end
      DRAIN: if (pipe_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      len_q   <= '0;
      acnt_q  <= '0;
      wcnt_q  <= '0;
      bank_q  <= 1'b0;
      lbb_a_q <= 1'b0;
      lbb_b_q <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      sel1_q  <= 1'b0;
      sel_q   <= 1'b0;
      vld_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
      wcnt_q  <= wcnt_d;
      bank_q  <= bank_d;
      if (cmd_hs) len_q <= cmd_len;
      // Target the bank not under compute, using the bank seen at acceptance.
      lbb_a_q <= w_hs && bank_q;
      lbb_b_q <= w_hs && !bank_q;
      d1_q    <= w_hs ? {8'h0, w_data} : (a_hs ? a_data : '0);
      d2_q    <= d1_q;
      sel1_q  <= bank_q;
      if (vld_q[1]) sel_q <= sel1_q;
      vld_q   <= {vld_q[RES_LAT-1:1], a_hs};
      last_q  <= {last_q[RES_LAT-1:1], a_hs && a_last};
    end
  end

  assign mac_data_in      = d2_q;
  assign mac_load_bb_a    = lbb_a_q;
  assign mac_load_bb_b    = lbb_b_q;
  assign mac_load_buf_sel = sel_q;
  assign mac_feed_sel     = 2'b00;
  assign res_valid        = vld_q[RES_LAT];
  assign res_last         = last_q[RES_LAT];
  assign mac_zero_en      = ~vld_q[RES_LAT];
  assign done             = (state_q == DRAIN) && pipe_empty;
  assign active_bank      = bank_q;
endmodule

// File: tb/tb_mac_int8_feeder.sv
// Scoreboard bench for mac_int8_feeder: drivers push expected strobes/data/results with
// their due cycle; a monitor compares every cycle against the queue heads.
module tb_mac_int8_feeder;
  logic        clk = 1'b0;
  logic        clr;
  logic        cmd_valid, cmd_ready, cmd_load_w;
  logic [7:0]  cmd_len;
  logic        w_valid, w_ready;
  logic [87:0] w_data;
  logic        a_valid, a_ready;
  logic [95:0] a_data;
  logic [95:0] mac_data_in;
  logic        mac_load_bb_a, mac_load_bb_b, mac_load_buf_sel;
  logic [1:0]  mac_feed_sel;
  logic        mac_zero_en, res_valid, res_last, done, active_bank;

  mac_int8_feeder dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load_w(cmd_load_w), .cmd_len(cmd_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .mac_data_in(mac_data_in), .mac_load_bb_a(mac_load_bb_a), .mac_load_bb_b(mac_load_bb_b),
    .mac_load_buf_sel(mac_load_buf_sel), .mac_feed_sel(mac_feed_sel), .mac_zero_en(mac_zero_en),
    .res_valid(res_valid), .res_last(res_last), .done(done), .active_bank(active_bank)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; bit to_a; } ld_t;
  typedef struct { int cyc; logic [95:0] d; bit chk_sel; bit sel; } dat_t;
  typedef struct { int cyc; bit last; } res_t;

  ld_t  lq[$];
  dat_t dq[$];
  res_t rq[$];
  int   done_q[$];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  bit model_bank = 1'b0;
  int cur_len = 0, wbeat = 0, abeat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string n, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", n, cyc, act, exp);
    end
  endtask

  task automatic chkw(input string n, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
    end
  endtask

  task automatic chki(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, act, exp);
    end
  endtask

  function automatic logic [79:0] rep8(input logic [7:0] b);
    return {10{b}};
  endfunction

  // Monitor: sample one time unit after each rising edge.
  ld_t  lh;
  dat_t dh;
  res_t rh;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (lq.size() > 0 && lq[0].cyc == cyc) begin
        lh = lq.pop_front();
        chk1("load_bb_a", mac_load_bb_a, lh.to_a);
        chk1("load_bb_b", mac_load_bb_b, !lh.to_a);
      end else begin
        chk1("load_bb_a_idle", mac_load_bb_a, 1'b0);
        chk1("load_bb_b_idle", mac_load_bb_b, 1'b0);
      end
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
        dh = dq.pop_front();
        chkw("data_in", mac_data_in, dh.d);
        if (dh.chk_sel) chk1("buf_sel", mac_load_buf_sel, dh.sel);
      end else begin
        chkw("data_in_idle", mac_data_in, 96'h0);
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        rh = rq.pop_front();
        chk1("res_valid", res_valid, 1'b1);
        chk1("zero_en", mac_zero_en, 1'b0);
        chk1("res_last", res_last, rh.last);
      end else begin
        chk1("res_valid_idle", res_valid, 1'b0);
        chk1("zero_en_idle", mac_zero_en, 1'b1);
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        void'(done_q.pop_front());
        chk1("done", done, 1'b1);
      end else begin
        chk1("done_idle", done, 1'b0);
      end
    end
  end

  task automatic wait_cmd_ready();
    int g = 0;
    while (!cmd_ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) begin total++; bad++; $display("FAIL cmd_ready_timeout cyc=%0d", cyc); end
  endtask

  task automatic send_cmd(input bit lw, input int len);
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_load_w = lw; cmd_len = len[7:0];
    if (!lw && len == 0) done_q.push_back(cyc + 1);
    cur_len = len; wbeat = 0; abeat = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] b, input int stall);
    int g = 0;
    w_valid = 1'b0;
    repeat (stall) @(negedge clk);
    w_data = {8'h0, rep8(b)};
    w_valid = 1'b1;
    while (!w_ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) begin total++; bad++; $display("FAIL w_ready_timeout cyc=%0d", cyc); end
    lq.push_back('{cyc + 1, model_bank});
    dq.push_back('{cyc + 2, {8'h0, w_data}, 1'b0, 1'b0});
    wbeat++;
    if (wbeat == 3) begin
      model_bank = ~model_bank;
      if (cur_len == 0) done_q.push_back(cyc + 1);
    end
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] b, input int stall);
    int g = 0;
    bit last;
    a_valid = 1'b0;
    repeat (stall) @(negedge clk);
    a_data = {16'h0, rep8(b)};
    a_valid = 1'b1;
    while (!a_ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) begin total++; bad++; $display("FAIL a_ready_timeout cyc=%0d", cyc); end
    abeat++;
    last = (abeat == cur_len);
    rq.push_back('{cyc + 5, last});
    dq.push_back('{cyc + 2, a_data, 1'b1, model_bank});
    if (last) done_q.push_back(cyc + 6);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  initial begin
    clr = 1'b0; cmd_valid = 1'b0; cmd_load_w = 1'b0; cmd_len = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    repeat (3) @(negedge clk);
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_zero_en", mac_zero_en, 1'b1);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_active_bank", active_bank, 1'b0);
    chkw("rst_data_in", mac_data_in, 96'h0);
    chk1("rst_feed_sel", |mac_feed_sel, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    chk1("post_rst_cmd_ready", cmd_ready, 1'b1);
    mon_en = 1'b1;

    // Load into bank B, one activation.
    send_cmd(1'b1, 1);
    send_w(8'd1, 0); send_w(8'd2, 0); send_w(8'd3, 0);
    send_a(8'd1, 0);
    wait_cmd_ready();
    chk1("bank_after_load1", active_bank, 1'b1);

    // Ping-pong into bank A.
    send_cmd(1'b1, 1);
    send_w(8'd4, 0); send_w(8'd5, 0); send_w(8'd6, 0);
    send_a(8'd1, 0);
    wait_cmd_ready();
    chk1("bank_after_load2", active_bank, 1'b0);

    // Stalled weights and activations.
    send_cmd(1'b1, 4);
    send_w(8'h11, 2); send_w(8'h12, 2); send_w(8'h13, 2);
    send_a(8'h21, 0); send_a(8'h22, 1); send_a(8'h23, 0); send_a(8'h24, 2);
    wait_cmd_ready();
    chk1("bank_after_load3", active_bank, 1'b1);

    // Zero-work command.
    send_cmd(1'b0, 0);
    wait_cmd_ready();

    // Reset with two results in flight.
    send_cmd(1'b0, 4);
    send_a(8'h31, 0); send_a(8'h32, 0);
    clr = 1'b0;
    lq.delete(); dq.delete(); rq.delete(); done_q.delete();
    model_bank = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk1("midrst_cmd_ready", cmd_ready, 1'b1);
    chk1("midrst_active_bank", active_bank, 1'b0);

    // Recovery: stream on bank A, then a load with zero activations.
    send_cmd(1'b0, 1);
    send_a(8'h41, 0);
    send_cmd(1'b1, 0);
    send_w(8'd7, 0); send_w(8'd8, 0); send_w(8'd9, 0);
    wait_cmd_ready();
    chk1("bank_after_load0", active_bank, 1'b1);

    repeat (10) @(negedge clk);
    chki("lq_empty", lq.size(), 0);
    chki("dq_empty", dq.size(), 0);
    chki("rq_empty", rq.size(), 0);
    chki("done_q_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_int8_feeder.md
Name: mac_int8_feeder

Overview:
- Sequencer that acts as the initiator of the MAC_INT8 control/data interface.
- Accepts commands, weight streams and activation streams over valid/ready handshakes.
- Loads 3-row weight sets into the MAC's inactive ping-pong bank, then streams activation vectors against the active bank.
- Emits a valid/last qualifier aligned with the MAC's result_h/result_l, and drives zero_en so the result bus reads zero when not valid.

Parameters:
- LEN_W, 8, width of the activation-count field cmd_len.
- RES_LAT, 5, cycles from activation-beat acceptance to valid MAC result; fixed by the MAC pipeline. Only 5 is supported.

Ports:
- clk  in  1  clock
- clr  in  1  reset; synchronous, active-low. The MAC's own clear is driven from ~clr.
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid; high only in IDLE
- cmd_load_w  in  1  1 = load a new 3-row weight set before streaming
- cmd_len  in  LEN_W  number of activation vectors to stream; 0 is legal
- w_valid  in  1  weight beat offered
- w_ready  out  1  weight beat accepted
- w_data  in  88  one weight row (10 INT8 lanes in [79:0])
- a_valid  in  1  activation beat offered
- a_ready  out  1  activation beat accepted
- a_data  in  96  activation vector (10 INT8 lanes in [79:0])
- mac_data_in  out  96  to MAC data_in
- mac_load_bb_a  out  1  to MAC load_bb_a
- mac_load_bb_b  out  1  to MAC load_bb_b
- mac_load_buf_sel  out  1  to MAC load_buf_sel (0 = bank A, 1 = bank B)
- mac_feed_sel  out  2  constant 2'b00 (weights taken from data_in)
- mac_zero_en  out  1  to MAC zero_en; equal to ~res_valid
- res_valid  out  1  MAC result_h/result_l valid this cycle
- res_last  out  1  last result of the current command
- done  out  1  one-cycle pulse when a command completes
- active_bank  out  1  bank currently used for compute

Behaviour:
- Reset (clr=0 at a clock edge) applies regardless of state and aborts any operation:
  - State IDLE; counters 0; active_bank=0.
  - All delay pipes cleared; outputs 0 except mac_zero_en=1.
  - Any beats in flight are discarded.
- FSM transitions:
  - IDLE → LOAD_W on cmd handshake with cmd_load_w=1.
  - IDLE → STREAM on cmd handshake with cmd_load_w=0 and cmd_len≠0.
  - IDLE → DRAIN on cmd handshake with cmd_load_w=0 and cmd_len=0.
  - LOAD_W → STREAM after the 3rd accepted weight beat if cmd_len≠0, else → DRAIN.
  - STREAM → DRAIN after beat number cmd_len is accepted.
  - DRAIN → IDLE when the result pipe is empty; done pulses on that transition cycle.
  - For a zero-work command, done pulses in the cycle after acceptance.
- cmd_len and cmd_load_w are latched at acceptance.
- Handshake outputs:
  - w_ready = (state==LOAD_W); a_ready = (state==STREAM).
  - Both are registered-state decodes with no combinational path from the valid inputs.
  - Stalls (valid low) are allowed at any beat; the counters advance only on handshake.
- Weight beat accepted at cycle t:
  - mac_load_bb_x=1 in cycle t+1, where x = ~active_bank (A when active_bank=1, B when 0).
  - mac_data_in = {8'h0, w_data} in cycle t+2. This matches the MAC's internal load register.
- Weight row order: the first beat ends in bank row 2, the third in row 0.
- After the 3rd weight beat is accepted, active_bank toggles in the same edge.
- Activation beat accepted at cycle t:
  - mac_data_in = a_data in cycle t+2.
  - mac_load_buf_sel = active_bank sampled at t, also in cycle t+2.
  - res_valid=1 in cycle t+5; res_last=1 on the beat numbered cmd_len.
- res_valid tracks accepted beats one-for-one. A stalled cycle produces a res_valid=0 hole.
- Hazard-free by construction:
  - The last weight row is written at the end of t+2.
  - The earliest dependent activation reaches the multipliers at t+4.
- Idle cycles (no beat): mac_data_in=0, load strobes 0, mac_load_buf_sel holds its last value.
- The loaded bank is never the one under compute. The previous bank contents are unaffected.

Test Plan:
- Reset: hold clr=0 for 3 cycles → cmd_ready=0 during reset then 1 after release; mac_zero_en=1; all other outputs 0; active_bank=0.
- Load then single activation:
  - Stimulus: cmd_load_w=1, cmd_len=1; weights with all bytes 1, then 2, then 3; activation with all bytes 1; MAC cascade_data_in tied 0.
  - Response: loads go to bank B; active_bank flips to 1; res_valid 5 cycles after the activation beat; MAC acc0=30, acc1=20, acc2=10, i.e. result_l={13'd20, 25'd30}; done pulses after.
- Ping-pong:
  - Stimulus: a second load command with bytes 4/5/6 and one activation of all 1s.
  - Response: mac_load_bb_a strobes; active_bank=0; acc0=60, acc1=50, acc2=40.
- Stalls:
  - Stimulus: w_valid low 2 cycles between each weight beat; a_valid toggling across 4 activations.
  - Response: exactly 3 load strobes; 4 res_valid pulses each 5 cycles after its beat; res_last only on the 4th.
- Zero-work command: cmd_load_w=0, cmd_len=0 → done in the cycle after acceptance, no strobes, no res_valid.
- Reset mid-stream:
  - Stimulus: clr=0 during STREAM with 2 results in flight.
  - Response: res_valid never asserts for them; state IDLE; active_bank=0; done not pulsed.
